// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul datapath and its stream unloader.
package matmul_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int M          = 32;
    localparam int IDX_W      = $clog2(M);
    localparam int DIM_W      = $clog2(M) + 1;
    localparam int EW         = 2 * DATA_WIDTH + $clog2(M);

    // One accumulated result element of the product matrix.
    typedef logic signed [EW-1:0] mat_elem;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } unload_state_t;

    // A transfer needs at least one row and one column, and must fit the array.
    function automatic logic dims_legal(input logic [DIM_W-1:0] r, input logic [DIM_W-1:0] c);
        return (r != '0) && (r <= DIM_W'(M)) && (c != '0) && (c <= DIM_W'(M));
    endfunction

    // Converts a legal (1..M) dimension into its last valid index.
    function automatic logic [IDX_W-1:0] dim_to_last_idx(input logic [DIM_W-1:0] d);
        logic [DIM_W-1:0] m1;
        m1 = d - DIM_W'(1);
        return m1[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/matmul_unloader.sv
// Streams a rows x cols window of the matmul result array out in row-major
// order, one element per accepted handshake. All outputs are registered.
module matmul_unloader
    import matmul_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DIM_W-1:0]        rows,
    input  logic [DIM_W-1:0]        cols,
    input  mat_elem [M-1:0][M-1:0]  mat,
    output mat_elem                 out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_row_last,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    unload_state_t    state_reg, state_next;
    logic [IDX_W-1:0] row_reg, row_next;
    logic [IDX_W-1:0] col_reg, col_next;
    logic [IDX_W-1:0] rows_m1_reg, rows_m1_next;
    logic [IDX_W-1:0] cols_m1_reg, cols_m1_next;
    mat_elem          data_reg, data_next;
    logic             valid_reg, valid_next;
    logic             row_last_reg, row_last_next;
    logic             last_reg, last_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic [IDX_W-1:0] adv_row;
    logic [IDX_W-1:0] adv_col;

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Counters, latched dimensions and the registered output stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_reg      <= '0;
            col_reg      <= '0;
            rows_m1_reg  <= '0;
            cols_m1_reg  <= '0;
            data_reg     <= '0;
            valid_reg    <= 1'b0;
            row_last_reg <= 1'b0;
            last_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
        end else begin
            row_reg      <= row_next;
            col_reg      <= col_next;
            rows_m1_reg  <= rows_m1_next;
            cols_m1_reg  <= cols_m1_next;
            data_reg     <= data_next;
            valid_reg    <= valid_next;
            row_last_reg <= row_last_next;
            last_reg     <= last_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
        end
    end

    // Next-state logic: the next element is preloaded on each handshake so the
    // stream sustains one beat per cycle and holds steady while stalled.
    always_comb begin
        state_next    = state_reg;
        row_next      = row_reg;
        col_next      = col_reg;
        rows_m1_next  = rows_m1_reg;
        cols_m1_next  = cols_m1_reg;
        data_next     = data_reg;
        valid_next    = valid_reg;
        row_last_next = row_last_reg;
        last_next     = last_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        err_next      = 1'b0;

        // Position following the current element in row-major order.
        if (col_reg == cols_m1_reg) begin
            adv_col = '0;
            adv_row = row_reg + IDX_W'(1);
        end else begin
            adv_col = col_reg + IDX_W'(1);
            adv_row = row_reg;
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (dims_legal(rows, cols)) begin
                        rows_m1_next  = dim_to_last_idx(rows);
                        cols_m1_next  = dim_to_last_idx(cols);
                        row_next      = '0;
                        col_next      = '0;
                        data_next     = mat[0][0];
                        valid_next    = 1'b1;
                        row_last_next = (cols == DIM_W'(1));
                        last_next     = (rows == DIM_W'(1)) && (cols == DIM_W'(1));
                        busy_next     = 1'b1;
                        state_next    = ST_STREAM;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                if (valid_reg && out_ready) begin
                    if (last_reg) begin
                        data_next     = '0;
                        valid_next    = 1'b0;
                        row_last_next = 1'b0;
                        last_next     = 1'b0;
                        done_next     = 1'b1;
                        state_next    = ST_DONE;
                    end else begin
                        row_next      = adv_row;
                        col_next      = adv_col;
                        data_next     = mat[adv_row][adv_col];
                        row_last_next = (adv_col == cols_m1_reg);
                        last_next     = (adv_row == rows_m1_reg) && (adv_col == cols_m1_reg);
                    end
                end
            end
            ST_DONE: begin
                busy_next  = 1'b0;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_data     = data_reg;
    assign out_valid    = valid_reg;
    assign out_row_last = row_last_reg;
    assign out_last     = last_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign err          = err_reg;

endmodule

// File: tb/tb_matmul_unloader.sv
// Directed bench for matmul_unloader: a queue of expected beats is built from
// the matrix and dimensions of every accepted start, and a single negedge
// process checks all outputs against it each cycle.
module tb_matmul_unloader;
    import matmul_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [DIM_W-1:0]       rows = '0;
    logic [DIM_W-1:0]       cols = '0;
    mat_elem [M-1:0][M-1:0] mat;
    mat_elem                out_data;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic                   out_row_last;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   err;

    matmul_unloader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rows         (rows),
        .cols         (cols),
        .mat          (mat),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row_last (out_row_last),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        mat_elem d;
        bit      rl;
        bit      l;
    } beat_t;

    beat_t   exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      done_pend = 0;
    bit      err_pend = 0;
    int      beats = 0;
    int      row_last_cnt = 0;
    int      done_cnt = 0;
    int      err_cnt = 0;
    int      first_hs = 0;
    int      last_hs = 0;
    mat_elem last_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Expected stream: row-major walk over the requested window.
    task automatic push_xfer(input int r, input int c);
        beat_t b;
        for (int i = 0; i < r; i++) begin
            for (int j = 0; j < c; j++) begin
                b.d  = mat[i][j];
                b.rl = (j == c - 1);
                b.l  = (i == r - 1) && (j == c - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic clear_stats();
        beats = 0; row_last_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_hs = 0; last_hs = 0; last_data = '0;
    endtask

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        beat_t e;
        if (done) done_cnt++;
        if (err) err_cnt++;
        check("err", err, err_pend);
        err_pend = 0;
        if (done_pend) begin
            check("done", done, 1);
            check("busy_in_done", busy, 1);
            check("valid_in_done", out_valid, 0);
            done_pend = 0;
        end else begin
            check("done", done, 0);
            check("busy", busy, exp_q.size() != 0);
            check("valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                check("data", out_data, e.d);
                check("row_last", out_row_last, e.rl);
                check("last", out_last, e.l);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    if (beats == 0) first_hs = cyc;
                    last_hs = cyc;
                    beats++;
                    if (e.rl) row_last_cnt++;
                    last_data = e.d;
                    if (e.l) done_pend = 1;
                end
            end
        end
    end

    task automatic do_start(input int r, input int c, input bit legal);
        @(posedge clk); #1;
        rows  = DIM_W'(r);
        cols  = DIM_W'(c);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (legal) push_xfer(r, c);
        else err_pend = 1;
    endtask

    task automatic wait_idle(input int max_cycles, input bit rnd_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_pend) && n < max_cycles) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        check("xfer_complete", (exp_q.size() == 0) && !done_pend, 1);
        out_ready = 1'b1;
    endtask

    task automatic fill_linear();
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                mat[i][j] = mat_elem'(i * M + j);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rnd;
        int          n;
        fill_linear();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_data", out_data, 0);
        check("rst_valid", out_valid, 0);
        check("rst_row_last", out_row_last, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Full 32x32, ready held high.
        out_ready = 1'b1;
        clear_stats();
        do_start(32, 32, 1);
        wait_idle(1200, 0);
        check("full_beats", beats, 1024);
        check("full_row_last", row_last_cnt, 32);
        check("full_last_data", last_data, 1023);
        check("full_span", last_hs - first_hs, 1023);
        check("full_done", done_cnt, 1);
        $display("xfer 32x32: %0d beats, %0d row ends, done %0d", beats, row_last_cnt, done_cnt);

        // 13x19 window of random signed values with extremes.
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++) begin
                rnd = {$urandom(), $urandom()};
                mat[i][j] = rnd[EW-1:0];
            end
        mat[0][0]   = '1;
        mat[5][7]   = {1'b1, {(EW-1){1'b0}}};
        mat[12][18] = {1'b0, {(EW-1){1'b1}}};
        clear_stats();
        do_start(13, 19, 1);
        wait_idle(400, 0);
        check("sub_beats", beats, 247);
        check("sub_row_last", row_last_cnt, 13);
        check("sub_last_data", last_data, 64'h0000_000F_FFFF_FFFF);
        $display("xfer 13x19: %0d beats, %0d row ends, done %0d", beats, row_last_cnt, done_cnt);

        // 4x4 with random backpressure.
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                mat[i][j] = mat_elem'(100 + i * 4 + j);
        out_ready = 1'b0;
        clear_stats();
        do_start(4, 4, 1);
        wait_idle(500, 1);
        check("bp_beats", beats, 16);
        check("bp_last_data", last_data, 115);
        check("bp_done", done_cnt, 1);
        $display("xfer 4x4 backpressure: %0d beats over %0d cycles", beats, last_hs - first_hs + 1);

        // Illegal dimensions, then a legal 2x2.
        clear_stats();
        do_start(0, 5, 0);
        do_start(4, 33, 0);
        repeat (3) @(posedge clk);
        #1;
        check("illegal_err_cnt", err_cnt, 2);
        check("illegal_beats", beats, 0);
        do_start(2, 2, 1);
        wait_idle(50, 0);
        check("after_illegal_beats", beats, 4);
        check("after_illegal_last", last_data, 105);
        $display("xfer illegal x2 then 2x2: err %0d, %0d beats", err_cnt, beats);

        // Reset after 100 beats of a full transfer.
        fill_linear();
        clear_stats();
        do_start(32, 32, 1);
        n = 0;
        while (beats < 100 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1 reset = 1'b1;
        exp_q.delete();
        done_pend = 0;
        #2;
        check("abort_beats", beats, 100);
        check("abort_last_data", last_data, 99);
        check("abort_valid", out_valid, 0);
        check("abort_data", out_data, 0);
        check("abort_last", out_last, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, 0);
        $display("xfer 32x32 aborted by reset after %0d beats", beats);

        // Single-element transfer after the abort.
        mat[0][0] = mat_elem'(-5);
        clear_stats();
        do_start(1, 1, 1);
        wait_idle(20, 0);
        check("one_beats", beats, 1);
        check("one_row_last", row_last_cnt, 1);
        check("one_data", last_data, 64'hFFFF_FFFF_FFFF_FFFB);
        check("one_done", done_cnt, 1);
        $display("xfer 1x1: %0d beat, data %0d", beats, last_data);

        // start held during streaming must be ignored.
        fill_linear();
        clear_stats();
        do_start(3, 5, 1);
        rows = DIM_W'(1);
        cols = DIM_W'(1);
        n = 0;
        while (exp_q.size() > 3 && n < 50) begin
            start = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        wait_idle(50, 0);
        check("restart_beats", beats, 15);
        check("restart_last_data", last_data, 68);
        check("restart_done", done_cnt, 1);
        check("restart_err", err_cnt, 0);
        $display("xfer 3x5 with start held: %0d beats, done %0d", beats, done_cnt);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
